// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - state encodings and width helpers for the PLL lock supervisor
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4,
    ST_PWRDN     = 3'd5
  } state_e;

  function automatic int retry_width(input int max_retries);
    return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
  endfunction

  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - sequences PLL reset/lock and gates the counters on a stable lock
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRIES  = 3
) (
  input  logic                                clk_100MHz_i,
  input  logic                                rst_n,
  input  logic                                pll_locked_i,
  input  logic                                pwrdn_req_i,
  input  logic                                en_req_i,
  input  logic                                fault_clr_i,
  output logic                                pll_rst_o,
  output logic                                pll_pwrdwn_o,
  output logic                                cnt_rst_o,
  output logic                                cnt_en_o,
  output logic [2:0]                          state_o,
  output logic [retry_width(MAX_RETRIES)-1:0] retry_cnt_o,
  output logic                                fault_o,
  output logic                                lock_lost_o
);

  localparam int RW = retry_width(MAX_RETRIES);
  localparam int TW = timer_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk  (clk_100MHz_i),
    .rst_n(rst_n),
    .d_i  (pll_locked_i),
    .q_o  (lock_s)
  );

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d, timer_inc;
  logic [RW-1:0] retry_q, retry_d;
  logic          fault_q, fault_d;
  logic          lock_lost_q, lock_lost_d;
  logic          pll_rst_q, pll_rst_d;
  logic          pll_pwrdwn_q, pll_pwrdwn_d;
  logic          cnt_rst_q, cnt_rst_d;
  logic          cnt_en_q, cnt_en_d;

  // Shared timer saturates so a stuck state can never alias back to an early count.
  assign timer_inc = (&timer_q) ? timer_q : timer_q + TW'(1);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_inc;
    retry_d     = retry_q;
    fault_d     = fault_q;
    lock_lost_d = 1'b0;

    if (pwrdn_req_i) begin
      state_d = ST_PWRDN;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (timer_q >= RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABILIZE;
            timer_d = '0;
          end else if (timer_q >= TIMEOUT_LAST) begin
            timer_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
            end else begin
              state_d = ST_RESET_PLL;
              retry_d = retry_q + RW'(1);
            end
          end
        end
        ST_STABILIZE: begin
          // A glitch just restarts the lock wait; it is not a failed attempt.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q >= STABLE_LAST) begin
            state_d = ST_RUN;
            timer_d = '0;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          timer_d = '0;
          if (!lock_s) begin
            state_d     = ST_RESET_PLL;
            lock_lost_d = 1'b1;
          end
        end
        ST_FAULT: begin
          timer_d = '0;
          if (fault_clr_i) begin
            state_d = ST_RESET_PLL;
            retry_d = '0;
            fault_d = 1'b0;
          end
        end
        ST_PWRDN: begin
          state_d = ST_RESET_PLL;
          timer_d = '0;
          retry_d = '0;
          fault_d = 1'b0;
        end
        default: begin
          state_d = ST_RESET_PLL;
          timer_d = '0;
        end
      endcase
    end

    pll_rst_d    = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT) || (state_d == ST_PWRDN);
    pll_pwrdwn_d = (state_d == ST_PWRDN);
    cnt_rst_d    = (state_d != ST_RUN);
    cnt_en_d     = (state_d == ST_RUN) && en_req_i;
  end

  always_ff @(posedge clk_100MHz_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RESET_PLL;
      timer_q      <= '0;
      retry_q      <= '0;
      fault_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
      pll_rst_q    <= 1'b1;
      pll_pwrdwn_q <= 1'b0;
      cnt_rst_q    <= 1'b1;
      cnt_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      fault_q      <= fault_d;
      lock_lost_q  <= lock_lost_d;
      pll_rst_q    <= pll_rst_d;
      pll_pwrdwn_q <= pll_pwrdwn_d;
      cnt_rst_q    <= cnt_rst_d;
      cnt_en_q     <= cnt_en_d;
    end
  end

  assign pll_rst_o    = pll_rst_q;
  assign pll_pwrdwn_o = pll_pwrdwn_q;
  assign cnt_rst_o    = cnt_rst_q;
  assign cnt_en_o     = cnt_en_q;
  assign state_o      = state_q;
  assign retry_cnt_o  = retry_q;
  assign fault_o      = fault_q;
  assign lock_lost_o  = lock_lost_q;

endmodule
